bw_io_hstl_rcv: RTL
===================

Name: bw_io_hstl_rcv

Overview:
Receive-side companion to the HSTL pad driver. Samples the single-ended HSTL pad net into the core clock domain through a 2-flop synchronizer, then applies a programmable glitch filter. It produces a clean level plus rise/fall pulses for the core. It also contains one boundary-scan input cell (capture/shift/update), so the pad participates in the same BSR chain as the driver.

Parameters:
CNT_W, 4, width of the filter-count input and the internal stability counter
RST_VAL, 1'b0, reset/por value of the synchronizer flops and the filtered level

Ports:
clk  input  1  core clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
pad  input  1  HSTL pad net (the driver weakly pulls undriven to 1)
por  input  1  power-on reset; 1 = receiver data path held inactive
rcv_en  input  1  receiver enable; 0 = data path frozen
filt_cnt  input  CNT_W  extra consecutive stable cycles required before a new level is accepted
sel_data_n  input  1  0 = rcv_data from filter; 1 = rcv_data from BSR update bit
bsr_capture  input  1  BSR capture-DR
bsr_shift  input  1  BSR shift-DR
bsr_update  input  1  BSR update-DR
bsr_si  input  1  BSR serial in
bsr_so  output  1  BSR serial out (= shift bit)
rcv_data  output  1  received level to core
rcv_rise  output  1  one-cycle pulse on filtered 0->1
rcv_fall  output  1  one-cycle pulse on filtered 1->0

Behaviour:
- Pad sampling: a sample is 1 only when pad==1'b1; 0/x/z all sample as 0 (z is already resolved to 1 on the net by the driver's pull-up).
- Data-path state: sync1, sync2, filt (1 bit each), cnt (CNT_W bits), rise_q, fall_q.
- Reset (rst=1): sync1=sync2=filt=RST_VAL, cnt=0, rise_q=fall_q=0, bsr shift bit=0, bsr update bit=0. rst has priority over everything.
- por=1 (rst=0): each cycle, data-path state is forced to its reset values. The BSR cell is unaffected by por.
- rcv_en=0 (rst=0, por=0): sync1, sync2 and filt hold. cnt is forced to 0 and rise_q=fall_q=0.
- Normal operation (rcv_en=1): sync1<=sample; sync2<=sync1.
  - Filter, when sync2==filt: cnt<=0.
  - Filter, when sync2!=filt and cnt>=filt_cnt: filt<=sync2 and cnt<=0.
  - Filter, otherwise: cnt<=cnt+1. cnt saturates at all-ones and never wraps.
- Filter latency: a pad level first sampled at edge N appears on filt at edge N+2+filt_cnt, provided it stays stable. With filt_cnt=0 that is edge N+2, i.e. 3 edges from the first sampling edge counted inclusive.
- Glitch rule: any return of sync2 to equal filt before acceptance clears cnt, and filt does not change.
- filt_cnt changing mid-count takes effect immediately, because the comparison uses >=. Lowering it below cnt causes acceptance on the next mismatch cycle.
- Edge pulses: rise_q<=1 on the cycle filt goes 0->1 and fall_q<=1 on 1->0; otherwise 0. rcv_rise = rise_q & ~sel_data_n; rcv_fall = fall_q & ~sel_data_n. Each pulse lasts exactly 1 cycle and aligns with the new rcv_data value.
- BSR cell priority: bsr_capture > bsr_shift.
  - capture: shift bit <= sync1. This is a raw sample, bypassing the filter.
  - shift: shift bit <= bsr_si.
  - update: updates the update bit <= shift bit (old value) independently, in the same cycle.
- bsr_so = shift bit (registered).
- Output mux: rcv_data = sel_data_n ? update bit : filt. This is combinational from registers, with no extra latency.

Test Plan:
- Reset: assert rst 2 cycles with pad=1 -> rcv_data=RST_VAL(0), rise/fall=0, bsr_so=0; then deassert, rcv_en=1, filt_cnt=0, pad=1 -> rcv_data=1 exactly 3 edges after the first sampling edge, rcv_rise high that one cycle only.
- Glitch filter: filt_cnt=3, filtered=0; pad=1 for 3 cycles then 0 -> rcv_data stays 0, no pulses. Next, pad=1 for 6 cycles -> rcv_data=1 at edge N+5, single rcv_rise.
- Pad z/x: drive pad=1'bx for 10 cycles from filtered=1 with filt_cnt=0 -> rcv_data falls to 0, one rcv_fall.
- por/rcv_en: por=1 mid-count while filtered=1 -> next edge rcv_data=0, cnt=0, no rcv_fall. Separately, rcv_en=0 while pad toggles -> rcv_data frozen, no pulses.
- BSR: pad=1 stable, capture 1 cycle -> bsr_so=1. Then shift with bsr_si=0,1 -> bsr_so=0 then 1. Then update with sel_data_n=1 -> rcv_data=1 next cycle. capture+shift in the same cycle -> capture wins.
- Edge suppression: sel_data_n=1 while filtered level toggles -> rcv_rise/rcv_fall stay 0, rcv_data follows the update bit.

Source files
------------

// File: rtl/bw_io_hstl_rcv.sv
// HSTL pad receiver: 2-flop synchronizer, programmable glitch filter with
// rise/fall pulses, and one boundary-scan input cell sharing the driver's BSR chain.
module bw_io_hstl_rcv #(
  parameter int   CNT_W   = 4,
  parameter logic RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pad,
  input  logic             por,
  input  logic             rcv_en,
  input  logic [CNT_W-1:0] filt_cnt,
  input  logic             sel_data_n,
  input  logic             bsr_capture,
  input  logic             bsr_shift,
  input  logic             bsr_update,
  input  logic             bsr_si,
  output logic             bsr_so,
  output logic             rcv_data,
  output logic             rcv_rise,
  output logic             rcv_fall
);

  logic             sample;
  logic             sync1;
  logic             sync2;
  logic             filt;
  logic [CNT_W-1:0] cnt;
  logic             rise_q;
  logic             fall_q;
  logic             shift_q;
  logic             update_q;

  // Only a solid 1 counts; an unresolved net must never look like a valid high.
  assign sample = (pad === 1'b1);

  // Data path: por reuses the reset values but leaves the BSR cell alone.
  always_ff @(posedge clk) begin
    if (rst || por) begin
      sync1  <= RST_VAL;
      sync2  <= RST_VAL;
      filt   <= RST_VAL;
      cnt    <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else if (!rcv_en) begin
      cnt    <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, forming a real 2-stage chain.
      sync1  <= sample;
      sync2  <= sync1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt >= filt_cnt) begin
        filt   <= sync2;
        cnt    <= '0;
        rise_q <= sync2;
        fall_q <= ~sync2;
      end else if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Capture takes the raw synchronized sample, bypassing the filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= 1'b0;
      update_q <= 1'b0;
    end else begin
      if (bsr_capture) begin
        shift_q <= sync1;
      end else if (bsr_shift) begin
        shift_q <= bsr_si;
      end
      if (bsr_update) begin
        update_q <= shift_q;
      end
    end
  end

  assign bsr_so   = shift_q;
  assign rcv_data = sel_data_n ? update_q : filt;
  assign rcv_rise = rise_q & ~sel_data_n;
  assign rcv_fall = fall_q & ~sel_data_n;

endmodule
